// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC decimator control path.
// - cic_ctrl_state_e : sequencer state encoding (2 bits)
// - CIC_MAX_SEL      : largest legal decimation selection k (R = 2^k)
// - CIC_SEL_W        : width of a decimation selection
// - clamp_sel()      : saturates a requested k to CIC_MAX_SEL
package cic_ctrl_pkg;

  localparam int unsigned CIC_SEL_W = 3;
  localparam logic [CIC_SEL_W-1:0] CIC_MAX_SEL = 3'd4;

  typedef enum logic [1:0] {
    CicStDisabled = 2'd0,
    CicStHold     = 2'd1,
    CicStSettle   = 2'd2,
    CicStRun      = 2'd3
  } cic_ctrl_state_e;

  function automatic logic [CIC_SEL_W-1:0] clamp_sel(logic [CIC_SEL_W-1:0] sel);
    return (sel > CIC_MAX_SEL) ? CIC_MAX_SEL : sel;
  endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Decimation-change request channel.
// - cfg_valid   : master offers a new selection
// - cfg_sel     : requested k
// - cfg_ready   : slave can take the selection this cycle
// - cfg_clamped : one-cycle pulse after an accepted out-of-range selection
// - cfg_done    : one-cycle pulse when the new selection is settled
interface cic_decim_ctrl_if;
  import cic_ctrl_pkg::*;

  logic                 cfg_valid;
  logic [CIC_SEL_W-1:0] cfg_sel;
  logic                 cfg_ready;
  logic                 cfg_clamped;
  logic                 cfg_done;

  modport master (
    output cfg_valid,
    output cfg_sel,
    input  cfg_ready,
    input  cfg_clamped,
    input  cfg_done
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sel,
    output cfg_ready,
    output cfg_clamped,
    output cfg_done
  );

endinterface

// File: rtl/cic_decim_ctrl.sv
// Run/reconfiguration sequencer for a 3-stage CIC decimator (R = 2^k, k 0..4).
// Owns the CIC enable and decim_sel inputs, applies new selections only while the
// CIC is disabled, and masks the transient output strobes after every (re)start.
// Ports:
// - clk, rst          : clock, synchronous active-high reset
// - clk_enable_i      : global qualifier; all state holds while low
// - start_i, stop_i   : level-sampled run / halt requests (stop wins)
// - cfg               : selection request channel (slave side)
// - cic_enable_o      : CIC enable
// - cic_decim_sel_o   : CIC decim_sel, always 0..4
// - cic_out_valid_i   : CIC out_valid
// - out_valid_o       : gated valid, same cycle as the CIC output data
// - busy_o            : high while flushing or settling
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned          N           = 3,
  parameter int unsigned          DISCARD     = N + 1,
  parameter int unsigned          FLUSH_CYC   = 4,
  parameter logic [CIC_SEL_W-1:0] DEFAULT_SEL = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_enable_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  cic_decim_ctrl_if.slave      cfg,
  output logic                 cic_enable_o,
  output logic [CIC_SEL_W-1:0] cic_decim_sel_o,
  input  logic                 cic_out_valid_i,
  output logic                 out_valid_o,
  output logic                 busy_o
);

  localparam logic [1:0] StDisabled = CicStDisabled;
  localparam logic [1:0] StHold     = CicStHold;
  localparam logic [1:0] StSettle   = CicStSettle;
  localparam logic [1:0] StRun      = CicStRun;

  localparam int unsigned CntMax = (DISCARD > FLUSH_CYC) ? DISCARD : FLUSH_CYC;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

  localparam logic [CntW-1:0] DiscLoad  = CntW'(DISCARD);
  localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYC);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntZero   = '0;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      disc_q, disc_d;
  logic [CntW-1:0]      flush_q, flush_d;
  logic                 cic_enable_q, cic_enable_d;
  logic [CIC_SEL_W-1:0] sel_q, sel_d;
  logic                 done_q, done_d;
  logic                 clamped_q, clamped_d;
  logic                 cfg_accept;

  assign cfg.cfg_ready = ~rst & ((state_q == StDisabled) | (state_q == StRun));

  // A stop in the same cycle as an offered selection drops the selection.
  assign cfg_accept = cfg.cfg_valid & cfg.cfg_ready & clk_enable_i & ~stop_i;

  always_comb begin
    state_d      = state_q;
    disc_d       = disc_q;
    flush_d      = flush_q;
    cic_enable_d = cic_enable_q;
    sel_d        = sel_q;
    done_d       = done_q;
    clamped_d    = clamped_q;

    if (clk_enable_i) begin
      done_d    = 1'b0;
      clamped_d = cfg_accept & (cfg.cfg_sel > CIC_MAX_SEL);
      if (cfg_accept) begin
        sel_d = clamp_sel(cfg.cfg_sel);
      end

      if (stop_i) begin
        state_d      = StDisabled;
        cic_enable_d = 1'b0;
      end else begin
        unique case (state_q)
          StDisabled: begin
            // A selection accepted in this same cycle lands in sel_d first.
            if (start_i) begin
              state_d      = StSettle;
              disc_d       = DiscLoad;
              cic_enable_d = 1'b1;
            end
          end
          StRun: begin
            // Enable falls on the same edge the new selection is applied.
            if (cfg_accept) begin
              state_d      = StHold;
              flush_d      = FlushLoad;
              cic_enable_d = 1'b0;
            end
          end
          StHold: begin
            // Leaving on the edge that sees 1 gives exactly FLUSH_CYC hold cycles.
            if (flush_q <= CntOne) begin
              state_d      = StSettle;
              disc_d       = DiscLoad;
              cic_enable_d = 1'b1;
            end else begin
              flush_d = flush_q - CntOne;
            end
          end
          StSettle: begin
            if (disc_q == CntZero) begin
              state_d = StRun;
              done_d  = 1'b1;
            end else if (cic_out_valid_i) begin
              // The strobe taking the count to zero is still masked.
              if (disc_q == CntOne) begin
                state_d = StRun;
                done_d  = 1'b1;
              end else begin
                disc_d = disc_q - CntOne;
              end
            end
          end
          default: begin
            state_d      = StDisabled;
            cic_enable_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StDisabled;
      disc_q       <= '0;
      flush_q      <= '0;
      cic_enable_q <= 1'b0;
      sel_q        <= clamp_sel(DEFAULT_SEL);
      done_q       <= 1'b0;
      clamped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      disc_q       <= disc_d;
      flush_q      <= flush_d;
      cic_enable_q <= cic_enable_d;
      sel_q        <= sel_d;
      done_q       <= done_d;
      clamped_q    <= clamped_d;
    end
  end

  assign cic_enable_o    = cic_enable_q;
  assign cic_decim_sel_o = sel_q;
  assign cfg.cfg_done    = done_q;
  assign cfg.cfg_clamped = clamped_q;

  // Unregistered so the CIC data bus needs no re-alignment.
  assign out_valid_o = cic_out_valid_i & (state_q == StRun) & ~rst;
  assign busy_o      = (state_q == StHold) | (state_q == StSettle);

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with default parameters
// (DISCARD = 4, FLUSH_CYC = 4, DEFAULT_SEL = 0).
module tb_cic_decim_ctrl;

  logic       clk;
  logic       rst;
  logic       clk_enable;
  logic       start;
  logic       stop;
  logic       cic_enable;
  logic [2:0] cic_decim_sel;
  logic       cic_out_valid;
  logic       out_valid;
  logic       busy;

  int checks;
  int errors;
  int done_cnt;
  int en_low;

  cic_decim_ctrl_if cfg_if ();

  cic_decim_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .clk_enable_i    (clk_enable),
    .start_i         (start),
    .stop_i          (stop),
    .cfg             (cfg_if),
    .cic_enable_o    (cic_enable),
    .cic_decim_sel_o (cic_decim_sel),
    .cic_out_valid_i (cic_out_valid),
    .out_valid_o     (out_valid),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    clk_enable       = 1'b1;
    start            = 1'b0;
    stop             = 1'b0;
    cic_out_valid    = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = 3'd0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(cfg_if.cfg_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_enable", 32'(cic_enable), 0);
    chk("rst_sel", 32'(cic_decim_sel), 0);
    chk("rst_done", 32'(cfg_if.cfg_done), 0);
    chk("rst_clamped", 32'(cfg_if.cfg_clamped), 0);
    chk("rst_busy", 32'(busy), 0);
    rst           = 1'b0;
    cic_out_valid = 1'b0;
    #1;
    chk("dis_ready", 32'(cfg_if.cfg_ready), 1);
    tick();

    // Start at R=1: four strobes masked, fifth passes, one cfg_done
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_enable", 32'(cic_enable), 1);
    chk("settle_ready", 32'(cfg_if.cfg_ready), 0);
    done_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      cic_out_valid = 1'b1;
      #1;
      chk("ov_r1", 32'(out_valid), 32'(i >= 5));
      done_cnt += int'(cfg_if.cfg_done);
      tick();
    end
    chk("done_r1", 32'(done_cnt), 1);
    chk("sel_r1", 32'(cic_decim_sel), 0);

    // Reconfigure to k=3 from RUN; cfg held during HOLD/SETTLE is refused
    cic_out_valid    = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 3'd3;
    #1;
    chk("run_ready", 32'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_sel = 3'd1;
    #1;
    chk("hold_sel", 32'(cic_decim_sel), 3);
    chk("hold_enable", 32'(cic_enable), 0);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_ready", 32'(cfg_if.cfg_ready), 0);
    en_low = 0;
    repeat (8) begin
      if (!cic_enable) en_low++;
      tick();
    end
    chk("hold_len", 32'(en_low), 4);
    chk("hold_sel_kept", 32'(cic_decim_sel), 3);
    cfg_if.cfg_valid = 1'b0;

    // R=8 strobes: four masked, then every eighth passes
    done_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      repeat (7) begin
        cic_out_valid = 1'b0;
        #1;
        done_cnt += int'(cfg_if.cfg_done);
        tick();
      end
      cic_out_valid = 1'b1;
      #1;
      chk("ov_r8", 32'(out_valid), 32'(i >= 5));
      done_cnt += int'(cfg_if.cfg_done);
      tick();
    end
    cic_out_valid = 1'b0;
    chk("done_r8", 32'(done_cnt), 1);

    // Stop, then an out-of-range selection while disabled
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_enable", 32'(cic_enable), 0);
    chk("stop_busy", 32'(busy), 0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 3'd7;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("clamp_sel", 32'(cic_decim_sel), 4);
    chk("clamp_pulse", 32'(cfg_if.cfg_clamped), 1);
    chk("dis_enable", 32'(cic_enable), 0);
    tick();
    chk("clamp_end", 32'(cfg_if.cfg_clamped), 0);

    // Stop mid-SETTLE after two discards, then a full restart
    start = 1'b1;
    tick();
    start         = 1'b0;
    cic_out_valid = 1'b1;
    tick();
    tick();
    cic_out_valid = 1'b0;
    stop          = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_enable", 32'(cic_enable), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(cfg_if.cfg_done), 0);
    start = 1'b1;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      cic_out_valid = 1'b1;
      #1;
      chk("ov_restart", 32'(out_valid), 32'(i >= 5));
      done_cnt += int'(cfg_if.cfg_done);
      tick();
    end
    cic_out_valid = 1'b0;
    chk("done_restart", 32'(done_cnt), 1);

    // stop and cfg_valid together in RUN: selection unchanged
    stop             = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 3'd6;
    tick();
    stop             = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("stopcfg_sel", 32'(cic_decim_sel), 4);
    chk("stopcfg_enable", 32'(cic_enable), 0);
    chk("stopcfg_clamped", 32'(cfg_if.cfg_clamped), 0);
    chk("stopcfg_busy", 32'(busy), 0);

    // clk_enable at 50% during HOLD: 4 enabled cycles = 8 clocks
    start = 1'b1;
    tick();
    start         = 1'b0;
    cic_out_valid = 1'b1;
    repeat (4) tick();
    cic_out_valid    = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 3'd1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    en_low = 0;
    for (int k = 0; k < 12; k++) begin
      clk_enable = (k % 2 == 1);
      if (!cic_enable) en_low++;
      tick();
    end
    clk_enable = 1'b1;
    chk("ce_hold_len", 32'(en_low), 8);
    chk("ce_sel", 32'(cic_decim_sel), 1);
    chk("ce_busy", 32'(busy), 1);

    // Reset mid-HOLD: back to DISABLED, no cfg_done
    cic_out_valid = 1'b1;
    repeat (4) tick();
    cic_out_valid    = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 3'd2;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("midrst_enable", 32'(cic_enable), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_sel", 32'(cic_decim_sel), 0);
    chk("midrst_ready", 32'(cfg_if.cfg_ready), 0);
    rst = 1'b0;
    tick();
    chk("midrst_done", 32'(cfg_if.cfg_done), 0);
    chk("midrst_enable2", 32'(cic_enable), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Run/reconfiguration sequencer for the 3-stage CIC decimator (R = 2^k, k 0..4). It owns the CIC `enable` and `decim_sel` inputs. It accepts decimation-change requests over a valid/ready handshake and applies them only while the CIC is disabled. Because the CIC integrators and comb delays are not cleared on reconfiguration, it suppresses the transient decimated outputs that follow every (re)start, so downstream FIR/comp stages only see settled samples.

## Interface
Parameters:
- `N`, 3: CIC order; sets the default discard depth.
- `DISCARD`, N+1: CIC output strobes suppressed after every start or reconfiguration.
- `FLUSH_CYC`, 4: enabled-clock cycles `cic_enable` is held low before a new selection is run.
- `DEFAULT_SEL`, 3'd0: `cic_decim_sel` after reset.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `clk_enable`  in  1: global clock qualifier. When low, all state holds.
- `start`  in  1: level-sampled run request.
- `stop`  in  1: level-sampled halt request. Has priority over `start` and `cfg_valid`.
- `cfg_valid`  in  1: new decimation selection offered.
- `cfg_sel`  in  3: requested k. Values >4 are clamped to 4.
- `cfg_ready`  out  1: selection can be accepted this cycle.
- `cfg_clamped`  out  1: one-cycle pulse when an accepted `cfg_sel` exceeded 4.
- `cfg_done`  out  1: one-cycle pulse when the new selection is settled and outputs flow.
- `cic_enable`  out  1: drives CIC `enable`.
- `cic_decim_sel`  out  3: drives CIC `decim_sel`, always 0..4.
- `cic_out_valid`  in  1: CIC `out_valid`.
- `out_valid`  out  1: gated valid passed downstream, aligned with CIC `out_sample`/`out_wide`.
- `busy`  out  1: high in HOLD or SETTLE.

## Operation
- States: DISABLED, HOLD, SETTLE, RUN. Reset state is DISABLED.
- All transitions and counter updates occur only when `clk_enable`=1. A handshake completes when `cfg_valid & cfg_ready & clk_enable`.
- `cfg_ready` = !rst & (state==DISABLED | state==RUN).
- **DISABLED**
  - Outputs: `cic_enable`=0.
  - Accepted cfg: `cic_decim_sel` takes min(cfg_sel,4) on the next edge; state stays DISABLED.
  - `start` & !`stop`: go to SETTLE and load `disc_cnt`=DISCARD. If a cfg is accepted in the same cycle, the new selection is the one used.
- **RUN**
  - Outputs: `cic_enable`=1, `out_valid`=`cic_out_valid`.
  - Accepted cfg: latch the clamped selection into `cic_decim_sel`, load `flush_cnt`=FLUSH_CYC, go to HOLD.
  - `stop`: go to DISABLED; a cfg in the same cycle is not accepted.
- **HOLD**
  - Outputs: `cic_enable`=0, `out_valid`=0.
  - `flush_cnt` decrements each enabled cycle. When it reaches 1, go to SETTLE with `disc_cnt`=DISCARD.
- **SETTLE**
  - Outputs: `cic_enable`=1, `out_valid`=0.
  - Each `cic_out_valid` decrements `disc_cnt`. The strobe that takes `disc_cnt` from 1 to 0 is still suppressed; the next state is RUN and `cfg_done` pulses in that first RUN cycle.
- `stop` in any state: DISABLED on the next enabled edge. Counters are abandoned; `cic_decim_sel` is kept.
- `cfg_clamped` pulses on the cycle after any accepted cfg with `cfg_sel`>4.
- `DISCARD`=0: SETTLE exits to RUN after one cycle without waiting for a strobe.

## Timing
- `cic_enable`, `cic_decim_sel`, `cfg_done`, `cfg_clamped` and state are registered.
- Combinational outputs:
  - `out_valid` = `cic_out_valid` & (state==RUN). Zero added latency, so the CIC data bus needs no re-alignment.
  - `busy` = (state==HOLD | state==SETTLE).
  - `cfg_ready`, as defined under Operation.
- Reset values: state DISABLED, `cic_enable`=0, `cic_decim_sel`=DEFAULT_SEL, `cfg_done`=0, `cfg_clamped`=0, counters 0.
- While `rst` is high: `out_valid`=0 and `cfg_ready`=0.
- Reset asserted mid-HOLD or mid-SETTLE: DISABLED on the next edge, with no `cfg_done`.
- `clk_enable` low: every register holds, and `out_valid` still follows the rule above.
- RUN to HOLD: `cic_enable` falls on the same edge that `cic_decim_sel` changes.
- A HOLD entered in cycle t lasts exactly FLUSH_CYC enabled cycles; `cic_enable` rises at enabled edge t+FLUSH_CYC.

## Structure
- Shared `cic_ctrl_pkg`:
  - state enum `cic_ctrl_state_e` (2 bits);
  - `CIC_MAX_SEL`=3'd4;
  - `CIC_SEL_W`=3;
  - function `clamp_sel(logic [2:0])`, reused by config-register blocks.
- Single module with no sub-module. The two down-counters are sized $clog2(max(DISCARD,FLUSH_CYC)+1).

## Test plan
- Reset then `start`=1 with CIC at R=1: first 4 `cic_out_valid` pulses masked, 5th passes, `cfg_done` pulses once, `cic_decim_sel`=0.
- In RUN, `cfg_valid`=1 with `cfg_sel`=3: `cic_enable` low for exactly 4 cycles, `cic_decim_sel`=3, 4 strobes masked at R=8, then `out_valid` every 8 input samples.
- `cfg_sel`=7 accepted in DISABLED: `cic_decim_sel`=4 and `cfg_clamped` pulses for 1 cycle.
- `stop` asserted mid-SETTLE after 2 discarded strobes: DISABLED next cycle, no `cfg_done`. A restart discards a full 4 strobes again.
- `cfg_valid` held during HOLD/SETTLE: `cfg_ready`=0 and no selection change. Same cycle `stop`+`cfg_valid` in RUN: DISABLED with the selection unchanged.
- `clk_enable` toggled 50% during HOLD: `cic_enable` stays low for 4 enabled cycles (8 clocks), and the state/counter hold when `clk_enable` is low.
